// File: rtl/imm_pkg.sv
// Shared types for the decode->execute immediate pipe.
// Enum of immediate formats, buffer states and a default-width entry view.
package imm_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 5;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_RSV = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } buf_st_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0]  imm;
    logic [XLEN_DEF-1:0]  pc;
    logic [XLEN_DEF-1:0]  tgt;
    logic [TAG_W_DEF-1:0] tag;
    logic                 ill;
  } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decode to XLEN bits.
// Signed fields are held in signed temporaries so a size cast sign-extends.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     instr_i,
  input  imm_src_e        src_i,
  output logic [XLEN-1:0] imm_o
);

  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;
  logic signed [31:0] u_imm;
  logic signed [20:0] j_imm;
  logic               unused_opc;

  assign i_imm = instr_i[31:20];
  assign s_imm = {instr_i[31:25], instr_i[11:7]};
  assign b_imm = {instr_i[31], instr_i[7],
                  instr_i[30:25], instr_i[11:8], 1'b0};
  assign u_imm = {instr_i[31:12], 12'b0};
  assign j_imm = {instr_i[31], instr_i[19:12],
                  instr_i[20], instr_i[30:21], 1'b0};
  assign unused_opc = ^instr_i[6:0];

  always_comb begin
    imm_o = '0;
    unique case (src_i)
      IMM_I:   imm_o = XLEN'(i_imm);
      IMM_S:   imm_o = XLEN'(s_imm);
      IMM_B:   imm_o = XLEN'(b_imm);
      IMM_U:   imm_o = XLEN'(u_imm);
      IMM_J:   imm_o = XLEN'(j_imm);
      IMM_Z:   imm_o = XLEN'(instr_i[19:15]);
      IMM_SH: begin
        if (XLEN == 64) imm_o = XLEN'(instr_i[25:20]);
        else            imm_o = XLEN'(instr_i[24:20]);
      end
      IMM_RSV: imm_o = '0;
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with 2-entry valid/ready skid buffer.
// Define IMM_ILLEGAL_CHK_EN to store/flag the reserved ImmSrc encoding.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      InstrD,
  input  logic [2:0]       ImmSrcD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [TAG_W-1:0] TagD,
  input  logic             FlushE,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ExtImmE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  TgtE,
  output logic [TAG_W-1:0] TagE,
  output logic             IllegalE
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  tgt;
    logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_CHK_EN
    logic             ill;
`endif
  } ent_t;

  imm_src_e        src;
  logic [XLEN-1:0] imm;
  ent_t            new_ent;
  ent_t            main_q, main_d;
  ent_t            skid_q, skid_d;
  buf_st_e         state_q, state_d;
  logic            push, pop;

  assign src = imm_src_e'(ImmSrcD);

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr_i (InstrD),
    .src_i   (src),
    .imm_o   (imm)
  );

  // Target is formed at push time so Execute sees a registered value.
  always_comb begin
    new_ent     = '0;
    new_ent.imm = imm;
    new_ent.pc  = PCD;
    new_ent.tgt = PCD + imm;
    new_ent.tag = TagD;
`ifdef IMM_ILLEGAL_CHK_EN
    new_ent.ill = (src == IMM_RSV);
`endif
  end

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Flush wins over both push and pop.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FlushE) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = new_ent;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = new_ent;
          end else if (push) begin
            skid_d  = new_ent;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign ExtImmE = main_q.imm;
  assign PCE     = main_q.pc;
  assign TgtE    = main_q.tgt;
  assign TagE    = main_q.tag;
`ifdef IMM_ILLEGAL_CHK_EN
  assign IllegalE = main_q.ill;
`else
  assign IllegalE = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe (XLEN=32 main DUT, XLEN=64 side DUT).
// Reference immediates are built from field arithmetic, not bit slicing.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, FlushE, out_valid, out_ready, IllegalE;
  logic [31:0] InstrD, PCD, ExtImmE, PCE, TgtE;
  logic [2:0]  ImmSrcD;
  logic [4:0]  TagD, TagE;

  logic        w_iv, w_ir, w_ov, w_ill;
  logic [31:0] w_instr;
  logic [2:0]  w_src;
  logic [63:0] w_pc, w_imm, w_pce, w_tgt;
  logic [4:0]  w_tag, w_tage;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .InstrD(InstrD), .ImmSrcD(ImmSrcD), .PCD(PCD), .TagD(TagD),
    .FlushE(FlushE), .out_valid(out_valid), .out_ready(out_ready),
    .ExtImmE(ExtImmE), .PCE(PCE), .TgtE(TgtE), .TagE(TagE),
    .IllegalE(IllegalE)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(w_iv), .in_ready(w_ir),
    .InstrD(w_instr), .ImmSrcD(w_src), .PCD(w_pc), .TagD(w_tag),
    .FlushE(1'b0), .out_valid(w_ov), .out_ready(1'b1),
    .ExtImmE(w_imm), .PCE(w_pce), .TgtE(w_tgt), .TagE(w_tage),
    .IllegalE(w_ill)
  );

  always #5 clk = ~clk;

`ifdef IMM_ILLEGAL_CHK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] imm;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_imm(input logic [31:0] ins,
                                          input int src, input int xl);
    longint v;
    case (src)
      0: begin
        v = longint'(ins[31:20]);
        if (ins[31]) v -= 4096;
      end
      1: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (ins[31]) v -= 4096;
      end
      2: begin
        v = 4096 * longint'(ins[31]) + 2048 * longint'(ins[7])
          + 32 * longint'(ins[30:25]) + 2 * longint'(ins[11:8]);
        if (ins[31]) v -= 8192;
      end
      3: begin
        v = 4096 * longint'(ins[31:12]);
        if (ins[31]) v -= (longint'(1) << 32);
      end
      4: begin
        v = (longint'(1) << 20) * longint'(ins[31])
          + 4096 * longint'(ins[19:12]) + 2048 * longint'(ins[20])
          + 2 * longint'(ins[30:21]);
        if (ins[31]) v -= (longint'(1) << 21);
      end
      5: v = longint'(ins[19:15]);
      6: v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    if (xl == 32) return 64'(v) & 64'hFFFF_FFFF;
    return 64'(v);
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [2:0] src, input logic [31:0] pc,
                       input logic [4:0] tag, input logic fl,
                       input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    InstrD    = ins;
    ImmSrcD   = src;
    PCD       = pc;
    TagD      = tag;
    FlushE    = fl;
    out_ready = ordy;
    #2;
    acc = v && in_ready && !fl;
    if (fl) begin
      q.delete();
    end else if (acc) begin
      e.imm = ref_imm(ins, int'(src), 32);
      e.pc  = 64'(pc);
      e.tgt = (64'(pc) + e.imm) & 64'hFFFF_FFFF;
      e.tag = tag;
      e.ill = ILL_EN && (src == 3'd7);
      q.push_back(e);
    end
  endtask

  logic        stall_prev = 1'b0;
  logic [31:0] p_imm, p_pc, p_tgt;
  logic [4:0]  p_tag;

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset && mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (out_valid && stall_prev) begin
        chk("stable_imm", 64'(ExtImmE), 64'(p_imm));
        chk("stable_tgt", 64'(TgtE), 64'(p_tgt));
        chk("stable_pc_tag", {PCE, 27'b0, TagE}, {p_pc, 27'b0, p_tag});
      end
      if (out_valid && out_ready && !FlushE && q.size() != 0) begin
        e = q.pop_front();
        chk("sb_imm", 64'(ExtImmE), e.imm);
        chk("sb_pc", 64'(PCE), e.pc);
        chk("sb_tgt", 64'(TgtE), e.tgt);
        chk("sb_tag", 64'(TagE), 64'(e.tag));
        chk("sb_ill", 64'(IllegalE), 64'(e.ill));
      end
      stall_prev = out_valid && !out_ready && !FlushE;
      p_imm = ExtImmE;
      p_pc  = PCE;
      p_tgt = TgtE;
      p_tag = TagE;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   n;
    reset = 1'b1;
    in_valid = 0; InstrD = 0; ImmSrcD = 0; PCD = 0; TagD = 0;
    FlushE = 0; out_ready = 0;
    w_iv = 0; w_instr = 0; w_src = 0; w_pc = 0; w_tag = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outs", {ExtImmE, TgtE}, 64'd0);
    chk("rst_pc_tag_ill", {PCE, TagE, IllegalE}, 64'd0);
    mon_en = 1'b1;

    drive(1, 32'hFFF0_0093, 3'd0, 32'h100, 5'd1, 0, 1, acc);
    drive(0, 0, 0, 0, 0, 0, 1, acc);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_imm", 64'(ExtImmE), 64'hFFFF_FFFF);
    chk("t1_tgt", 64'(TgtE), 64'h0FF);

    drive(1, 32'hFE00_0EE3, 3'd2, 32'h200, 5'd2, 0, 1, acc);
    drive(0, 0, 0, 0, 0, 0, 1, acc);
    chk("t2_imm", 64'(ExtImmE), 64'hFFFF_FFFC);
    chk("t2_tgt", 64'(TgtE), 64'h1FC);

    drive(1, 32'h03F0_0013, 3'd6, 32'h0, 5'd3, 0, 1, acc);
    drive(0, 0, 0, 0, 0, 0, 1, acc);
    chk("sh32_imm", 64'(ExtImmE), 64'd31);

    drive(1, 32'h0000_0000, 3'd7, 32'h40, 5'd4, 0, 1, acc);
    drive(0, 0, 0, 0, 0, 0, 1, acc);
    chk("rsv_imm", 64'(ExtImmE), 64'd0);
    chk("rsv_ill", 64'(IllegalE), 64'(ILL_EN));

    @(negedge clk);
    w_iv = 1; w_instr = 32'h8000_00B7; w_src = 3'd3; w_pc = 64'h1000;
    @(negedge clk);
    w_iv = 1; w_instr = 32'h03F0_0013; w_src = 3'd6; w_pc = 64'h0;
    #2;
    chk("u64_imm", w_imm, 64'hFFFF_FFFF_8000_0000);
    chk("u64_tgt", w_tgt, 64'hFFFF_FFFF_8000_1000);
    @(negedge clk);
    w_iv = 0;
    #2;
    chk("sh64_imm", w_imm, 64'd63);

    drive(1, 32'h0010_0093, 3'd0, 32'hA0, 5'd10, 0, 0, acc);
    chk("bp_A", 64'(acc), 64'd1);
    drive(1, 32'h0020_0093, 3'd0, 32'hB0, 5'd11, 0, 0, acc);
    chk("bp_B", 64'(acc), 64'd1);
    drive(1, 32'h0030_0093, 3'd0, 32'hC0, 5'd12, 0, 0, acc);
    chk("bp_C_refused", 64'(acc), 64'd0);
    n = 0;
    acc = 0;
    while (!acc && n < 10) begin
      drive(1, 32'h0030_0093, 3'd0, 32'hC0, 5'd12, 0, 1, acc);
      n++;
    end
    chk("bp_C_taken", 64'(acc), 64'd1);
    n = 0;
    while (q.size() != 0 && n < 10) begin
      drive(0, 0, 0, 0, 0, 0, 1, acc);
      n++;
    end
    chk("bp_drained", 64'(q.size()), 64'd0);

    drive(1, 32'h1111_1013, 3'd1, 32'h300, 5'd5, 0, 0, acc);
    drive(1, 32'h2222_2013, 3'd4, 32'h304, 5'd6, 0, 0, acc);
    drive(1, 32'h3333_3013, 3'd3, 32'h308, 5'd7, 1, 0, acc);
    drive(0, 0, 0, 0, 0, 0, 1, acc);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);

    drive(1, 32'h7FF0_0013, 3'd0, 32'h400, 5'd9, 0, 0, acc);
    drive(0, 0, 0, 0, 0, 0, 0, acc);
    chk("rm_pre_valid", 64'(out_valid), 64'd1);
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rm_out_valid", 64'(out_valid), 64'd0);
    chk("rm_outs", {ExtImmE, TgtE}, 64'd0);
    chk("rm_pc_tag_ill", {PCE, TagE, IllegalE}, 64'd0);
    q.delete();
    @(negedge clk);
    in_valid = 0;
    reset = 1'b0;
    #1;
    chk("rm_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom,
            3'($urandom_range(0, 7)), $urandom, 5'($urandom),
            $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6, acc);
    end
    n = 0;
    while (q.size() != 0 && n < 10) begin
      drive(0, 0, 0, 0, 0, 0, 1, acc);
      n++;
    end
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
